// File: rtl/mux_2_1.sv
// 2:1 data selector with a registered copy of the selected data and a
// saturating count of select-line transitions for bring-up visibility.

module mux_2_1_lane (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic d0_i,
  input  logic d1_i,
  input  logic sel_i,
  output logic y_o,
  output logic y_q_o
);

  logic y_q;

  // Combinational path stays live during reset; only the copy is cleared.
  assign y_o = sel_i ? d1_i : d0_i;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) y_q <= 1'b0;
    else         y_q <= y_o;
  end

  assign y_q_o = y_q;

endmodule

module mux_2_1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic             sel_0,
  output logic [WIDTH-1:0] out_0,
  output logic [WIDTH-1:0] out_0_q,
  output logic [CNT_W-1:0] sel_cnt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    mux_2_1_lane u_lane (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .d0_i    (in_0[i]),
      .d1_i    (in_1[i]),
      .sel_i   (sel_0),
      .y_o     (out_0[i]),
      .y_q_o   (out_0_q[i])
    );
  end

  logic             sel_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // sel_q resets to 0, so a high select on the first cycle out of reset counts.
  always_comb begin
    cnt_d = cnt_q;
    if ((sel_0 != sel_q) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sel_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_0;
      cnt_q <= cnt_d;
    end
  end

  assign sel_cnt = cnt_q;

endmodule

// File: tb/tb_mux_2_1.sv
// Scoreboard bench for mux_2_1: stimulus queues expectations, monitor compares.

module tb_mux_2_1;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [0:0] in_0, in_1;
  logic       sel_0;
  logic [0:0] out_0, out_0_q, out_0_s, out_0_q_s;
  logic [15:0] sel_cnt;
  logic [1:0]  sel_cnt_s;

  always #10 sys_clk = ~sys_clk;

  mux_2_1 #(.WIDTH(1), .CNT_W(16)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_0(in_0), .in_1(in_1),
    .sel_0(sel_0), .out_0(out_0), .out_0_q(out_0_q), .sel_cnt(sel_cnt)
  );

  mux_2_1 #(.WIDTH(1), .CNT_W(2)) u_sat (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_0(in_0), .in_1(in_1),
    .sel_0(sel_0), .out_0(out_0_s), .out_0_q(out_0_q_s), .sel_cnt(sel_cnt_s)
  );

  typedef enum int {T_OUT, T_Q, T_CNT, T_CNT2} chk_t;
  typedef struct {
    chk_t        typ;
    logic [15:0] exp;
    string       name;
  } sb_item_t;

  sb_item_t sb[$];
  event     sb_ev;
  int       n_chk  = 0;
  int       n_fail = 0;

  task automatic expect_v(input chk_t typ, input logic [15:0] exp, input string name);
    sb_item_t it;
    it.typ = typ; it.exp = exp; it.name = name;
    sb.push_back(it);
  endtask

  // Hands queued expectations to the monitor, then lets it sample before moving on.
  task automatic flush();
    -> sb_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin : monitor
    sb_item_t    it;
    logic [15:0] act;
    forever begin
      @(sb_ev);
      while (sb.size() != 0) begin
        it = sb.pop_front();
        case (it.typ)
          T_OUT:   act = {15'd0, out_0};
          T_Q:     act = {15'd0, out_0_q};
          T_CNT:   act = sel_cnt;
          default: act = {14'd0, sel_cnt_s};
        endcase
        n_chk++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h at %0t", it.name, act, it.exp, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // {in_0, in_1, sel_0, expected out_0}
  logic [3:0] comb_tbl [8] = '{4'b0000, 4'b1001, 4'b0100, 4'b1101,
                               4'b0010, 4'b1010, 4'b0111, 4'b1111};
  logic [1:0] sat_tbl  [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
  logic       tog_pat  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin : stim
    logic [3:0]  v;
    logic        m_q, m_seld;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;
    logic        a0, a1, as, b0, b1, bs, br;

    // 1: reset with combinational path live
    sys_rst = 1'b1; in_0 = 1'b1; in_1 = 1'b0; sel_0 = 1'b0;
    #1;
    expect_v(T_OUT, 16'd1, "reset_out0"); flush();
    tick(); tick();
    expect_v(T_OUT, 16'd1, "reset_out0_after");
    expect_v(T_Q,   16'd0, "reset_q");
    expect_v(T_CNT, 16'd0, "reset_cnt");
    expect_v(T_CNT2, 16'd0, "reset_cnt2");
    flush();

    // 2: exhaustive combinational, one vector every 10 ns
    sys_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = comb_tbl[i];
      in_0 = v[3]; in_1 = v[2]; sel_0 = v[1];
      #1;
      expect_v(T_OUT, {15'd0, v[0]}, $sformatf("comb_%0d", i)); flush();
      #8;
    end

    // 3: register latency
    sys_rst = 1'b1; tick();
    sys_rst = 1'b0; in_0 = 1'b0; in_1 = 1'b0; sel_0 = 1'b0;
    tick();
    in_0 = 1'b0; in_1 = 1'b1; sel_0 = 1'b1;
    #1;
    expect_v(T_OUT, 16'd1, "lat_out0_cycN");
    expect_v(T_Q,   16'd0, "lat_q_before_edge");
    flush();
    tick();
    expect_v(T_Q,   16'd1, "lat_q_after_edge");
    expect_v(T_CNT, 16'd1, "lat_cnt");
    flush();

    // 4: toggle count, then reset racing a toggle
    sys_rst = 1'b1; sel_0 = 1'b0; tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel_0 = tog_pat[i];
      tick();
    end
    expect_v(T_CNT, 16'd3, "toggle_cnt");
    expect_v(T_CNT2, 16'd3, "toggle_cnt2");
    flush();
    sys_rst = 1'b1; sel_0 = 1'b0; tick();
    expect_v(T_CNT, 16'd0, "reset_wins_cnt");
    expect_v(T_Q,   16'd0, "reset_wins_q");
    flush();
    sys_rst = 1'b0; tick();
    expect_v(T_CNT, 16'd0, "post_reset_no_toggle");
    flush();

    // 5: saturation on the 2-bit counter
    for (int i = 0; i < 6; i++) begin
      sel_0 = ~sel_0;
      tick();
      expect_v(T_CNT2, {14'd0, sat_tbl[i]}, $sformatf("sat_%0d", i)); flush();
    end
    expect_v(T_CNT, 16'd6, "wide_cnt_6"); flush();

    // 6: random stimulus against a reference model
    sys_rst = 1'b1; tick();
    sys_rst = 1'b0;
    m_q = 1'b0; m_seld = 1'b0; m_cnt = '0; m_cnt2 = '0;
    for (int c = 0; c < 1000; c++) begin
      a0 = 1'($urandom); a1 = 1'($urandom); as = 1'($urandom);
      in_0 = a0; in_1 = a1; sel_0 = as;
      #1;
      expect_v(T_OUT, {15'd0, as ? a1 : a0}, "rnd_out0_a"); flush();
      #7;
      b0 = 1'($urandom); b1 = 1'($urandom); bs = 1'($urandom);
      br = ($urandom_range(0, 49) == 0);
      in_0 = b0; in_1 = b1; sel_0 = bs; sys_rst = br;
      #1;
      expect_v(T_OUT, {15'd0, bs ? b1 : b0}, "rnd_out0_b"); flush();
      if (br) begin
        m_q = 1'b0; m_cnt = '0; m_cnt2 = '0; m_seld = 1'b0;
      end else begin
        m_q = bs ? b1 : b0;
        if (bs != m_seld) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (m_cnt2 != 2'd3)    m_cnt2 = m_cnt2 + 2'd1;
        end
        m_seld = bs;
      end
      tick();
      sys_rst = 1'b0;
      expect_v(T_Q,    {15'd0, m_q},  "rnd_q");
      expect_v(T_CNT,  m_cnt,         "rnd_cnt");
      expect_v(T_CNT2, {14'd0, m_cnt2}, "rnd_cnt2");
      flush();
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) #1;
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
